// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key encoder: frame FSM states, scan-code
// prefixes and the field layout of the ps2_key event word.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    localparam int unsigned KEY_TOGGLE_BIT  = 10;
    localparam int unsigned KEY_PRESSED_BIT = 9;
    localparam int unsigned KEY_EXT_BIT     = 8;
    localparam int unsigned KEY_CODE_MSB    = 7;

    // Odd parity: the data bits plus the parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer for one raw PS/2 line, followed by an optional counter glitch
// filter enabled by PS2_KEY_FILTER_EN. Output resets high (idle line level).
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic line_i,
    output logic line_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], line_i};
        end
    end

`ifdef PS2_KEY_FILTER_EN
    localparam int unsigned CntW = $clog2(FILTER_LEN);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            filt_q, filt_d;

    // Flip only on the FILTER_LEN-th consecutive disagreeing sample.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CntW'(FILTER_LEN - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign line_o = filt_q;
`else
    logic unused_filter_len;
    assign unused_filter_len = ^FILTER_LEN;
    assign line_o = sync_q[1];
`endif

endmodule

// File: rtl/ps2_key_encoder.sv
// Decodes a raw PS/2 keyboard clock/data pair into the 11-bit ps2_key event word
// {toggle, pressed, extended, code}. Optional line glitch filter: PS2_KEY_FILTER_EN.
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 96000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int unsigned        TmoW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0]    TmoMax  = TmoW'(TIMEOUT_CYCLES);
    localparam logic [TmoW-1:0]    TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    logic clk_f, data_f;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .line_i  (ps2_clk),
        .line_o  (clk_f)
    );

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_data_filter (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .line_i  (ps2_data),
        .line_o  (data_f)
    );

    logic clk_prev_q, fall_q, bit_q;

    // Registered falling-edge pulse with the data bit captured alongside it.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
            bit_q      <= 1'b1;
        end else begin
            clk_prev_q <= clk_f;
            fall_q     <= clk_prev_q & ~clk_f;
            bit_q      <= data_f;
        end
    end

    ps2_state_e      state_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic [TmoW-1:0] tmo_cnt_q;
    logic            ext_q, brk_q;
    logic [2:0]      skip_q;
    logic            tmo_hit;

    // A falling edge on the expiring cycle takes precedence over the timeout.
    assign tmo_hit = (state_q != IDLE) && !fall_q && (tmo_cnt_q == TmoLast);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_cnt_q <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            skip_q    <= '0;
            ps2_key   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            if (state_q == IDLE || fall_q) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q != TmoMax) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end

            if (tmo_hit) begin
                state_q   <= IDLE;
                frame_err <= 1'b1;
                ext_q     <= 1'b0;
                brk_q     <= 1'b0;
            end else if (fall_q) begin
                unique case (state_q)
                    IDLE: begin
                        if (!bit_q) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {bit_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_q   <= bit_q;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (!odd_parity_ok(shift_q, par_q) || !bit_q) begin
                            frame_err <= 1'b1;
                            ext_q     <= 1'b0;
                            brk_q     <= 1'b0;
                        end else if (skip_q != 3'd0) begin
                            skip_q <= skip_q - 1'b1;
                        end else if (shift_q == PS2_EXT) begin
                            ext_q <= 1'b1;
                        end else if (shift_q == PS2_BRK) begin
                            brk_q <= 1'b1;
                        end else if (shift_q == PS2_PAUSE) begin
                            skip_q <= PS2_PAUSE_SKIP;
                        end else begin
                            ps2_key[KEY_TOGGLE_BIT]   <= ~ps2_key[KEY_TOGGLE_BIT];
                            ps2_key[KEY_PRESSED_BIT]  <= ~brk_q;
                            ps2_key[KEY_EXT_BIT]      <= ext_q;
                            ps2_key[KEY_CODE_MSB:0]   <= shift_q;
                            ext_q                     <= 1'b0;
                            brk_q                     <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Self-checking bench for ps2_key_encoder: directed PS/2 frames, a byte-level event model
// with a per-cycle compare process, and literal expectations after each scenario.
module tb_ps2_key_encoder;

    localparam int unsigned FL  = 4;
    localparam int unsigned TMO = 400;
    localparam int unsigned H   = 20;
`ifdef PS2_KEY_FILTER_EN
    localparam int LAT = 4 + FL;
`else
    localparam int LAT = 4;
`endif

    logic        clk_sys  = 1'b0;
    logic        reset_n  = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    ps2_key_encoder #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          is_err;
        logic [10:0] key;
    } ev_t;

    ev_t         pend[$];
    logic [10:0] m_key = '0;
    logic        m_ext = 1'b0;
    logic        m_brk = 1'b0;
    int          m_skip = 0;
    logic [10:0] exp_key = '0;
    bit          chk_en = 1'b0;
    int          n_vec = 0;
    int          n_fail = 0;
    int          err_seen = 0;

    // Byte-level meaning of a good frame; events land LAT cycles after the stop edge.
    task automatic model_byte(input logic [7:0] b, input int due);
        if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else begin
            m_key = {~m_key[10], ~m_brk, m_ext, b};
            pend.push_back('{due, 1'b0, m_key});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_err(input int due);
        pend.push_back('{due, 1'b1, 11'h000});
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    always @(negedge clk_sys) begin
        if (chk_en) begin
            logic exp_err;
            exp_err = 1'b0;
            while (pend.size() != 0 && pend[0].due == cyc) begin
                if (pend[0].is_err) exp_err = 1'b1;
                else exp_key = pend[0].key;
                void'(pend.pop_front());
            end
            n_vec++;
            if (ps2_key !== exp_key) begin
                n_fail++;
                $display("FAIL ps2_key @cyc %0d: got %h, want %h", cyc, ps2_key, exp_key);
            end
            n_vec++;
            if (frame_err !== exp_err) begin
                n_fail++;
                $display("FAIL frame_err @cyc %0d: got %b, want %b", cyc, frame_err, exp_err);
            end
            if (frame_err === 1'b1) err_seen++;
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n, output int last_c);
        last_c = 0;
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_neg(H);
            ps2_clk = 1'b0;
            last_c  = cyc;
            wait_neg(H);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        int          c;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        send_bits(bits, 10, c);
        ps2_data = bits[10];
        wait_neg(H);
        ps2_clk = 1'b0;
        if (bad_par || bad_stop) model_err(cyc + LAT);
        else model_byte(b, cyc + LAT);
        wait_neg(H);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_neg(2 * H);
    endtask

    initial begin
        int c;
        logic [7:0] pause_seq [8];
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        wait_neg(3);
        check_lit("reset_key", 32'(ps2_key), 32'h000);
        check_lit("reset_err", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        wait_neg(5);

        send_frame(8'h1C, 1'b0, 1'b0);
        check_lit("make_1c", 32'(ps2_key), 32'h61C);

        send_frame(8'hF0, 1'b0, 1'b0);
        check_lit("f0_no_toggle", 32'(ps2_key), 32'h61C);
        send_frame(8'h1C, 1'b0, 1'b0);
        check_lit("break_1c", 32'(ps2_key), 32'h01C);

        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check_lit("ext_75", 32'(ps2_key), 32'h775);
        send_frame(8'h6B, 1'b0, 1'b0);
        check_lit("plain_6b", 32'(ps2_key), 32'h26B);

        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b0);
        check_lit("bad_parity_hold", 32'(ps2_key), 32'h26B);
        check_lit("bad_parity_errs", 32'(err_seen), 32'd1);
        send_frame(8'h1C, 1'b0, 1'b0);
        check_lit("brk_cleared", 32'(ps2_key), 32'h61C);

        send_frame(8'hF0, 1'b0, 1'b0);
        send_bits({3'b111, 8'h5A}, 5, c);
        ps2_data = 1'b1;
        model_err(c + LAT + TMO);
        wait_neg(TMO + 10);
        check_lit("timeout_errs", 32'(err_seen), 32'd2);
        send_frame(8'h29, 1'b0, 1'b0);
        check_lit("after_timeout_29", 32'(ps2_key), 32'h229);

`ifdef PS2_KEY_FILTER_EN
        ps2_data = 1'b0;
        wait_neg(10);
        ps2_clk = 1'b0;
        wait_neg(3);
        ps2_clk = 1'b1;
        wait_neg(10);
        ps2_data = 1'b1;
        wait_neg(20);
`endif

        for (int i = 0; i < 8; i++) send_frame(pause_seq[i], 1'b0, 1'b0);
        check_lit("pause_silent", 32'(ps2_key), 32'h229);
        send_frame(8'h16, 1'b0, 1'b0);
        check_lit("after_pause_16", 32'(ps2_key), 32'h616);

        send_frame(8'h1C, 1'b0, 1'b1);
        check_lit("bad_stop_hold", 32'(ps2_key), 32'h616);
        check_lit("bad_stop_errs", 32'(err_seen), 32'd3);

        send_bits({3'b111, 8'h33}, 3, c);
        ps2_data = 1'b1;
        chk_en   = 1'b0;
        reset_n  = 1'b0;
        pend.delete();
        m_key = '0; m_ext = 1'b0; m_brk = 1'b0; m_skip = 0; exp_key = '0;
        wait_neg(2);
        check_lit("midframe_reset_key", 32'(ps2_key), 32'h000);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        wait_neg(TMO + 20);
        check_lit("no_err_after_reset", 32'(err_seen), 32'd3);
        send_frame(8'h16, 1'b0, 1'b0);
        check_lit("post_reset_16", 32'(ps2_key), 32'h616);

        wait_neg(20);
        check_lit("events_drained", 32'(pend.size()), 32'd0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
